// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the simple CPU.
// Owns the architectural registers, the program loader and the shared
// memory write port, and sequences free-run / single-step execution.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for load_start or start; registers hold
// LOAD  | accepting program bytes into memory from address 0
// RUN   | executing; commits next-state values on each commit cycle
// HALT  | stopped by a halt opcode or abort; registers hold
module cpu_run_ctrl #(
  parameter int MEMSIZE = 64,
  parameter int CNT_W   = 16,
  localparam int AW     = $clog2(MEMSIZE)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load_start,
  input  logic               i_load_valid,
  input  logic [7:0]         i_load_data,
  input  logic               i_load_last,
  output logic               o_load_ready,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic [7:0]         i_ope,
  input  logic [7:0]         i_next_a,
  input  logic [7:0]         i_next_b,
  input  logic [7:0]         i_next_c,
  input  logic [7:0]         i_next_d,
  input  logic [7:0]         i_next_sp,
  input  logic [7:0]         i_next_ip,
  input  logic               i_next_zf,
  input  logic               i_write_flag,
  input  logic [MEMSIZE-1:0] i_write_addr,
  input  logic [7:0]         i_write_value,
  output logic [7:0]         o_a,
  output logic [7:0]         o_b,
  output logic [7:0]         o_c,
  output logic [7:0]         o_d,
  output logic [7:0]         o_sp,
  output logic [7:0]         o_ip,
  output logic               o_zf,
  output logic               o_mem_we,
  output logic [AW-1:0]      o_mem_addr,
  output logic [7:0]         o_mem_wdata,
  output logic [1:0]         o_state,
  output logic               o_halted,
  output logic [CNT_W-1:0]   o_retired
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // Stack pointer starts just past the top of memory; first push lands at MEMSIZE-1.
  localparam logic [7:0]    SP_INIT = 8'(MEMSIZE);
  localparam logic [AW-1:0] PTR_MAX = AW'(MEMSIZE - 1);

  state_t           r_state;
  logic [AW-1:0]    r_ptr;
  logic [7:0]       r_a, r_b, r_c, r_d, r_sp, r_ip;
  logic             r_zf;
  logic [CNT_W-1:0] r_retired;

  logic w_commit;
  logic w_halt_op;
  logic w_exec;
  logic w_load_acc;
  logic w_load_done;
  logic w_ret_max;

  // Only the low AW address bits and the opcode class bits matter here.
  logic w_unused_addr;
  logic w_unused_ope;
  assign w_unused_addr = ^i_write_addr[MEMSIZE-1:AW];
  assign w_unused_ope  = ^i_ope[3:0];

  assign w_commit    = i_step_mode ? i_step : 1'b1;
  assign w_halt_op   = i_ope[7] & ((i_ope[6:4] == 3'b010) |
                                   (i_ope[6:4] == 3'b011) |
                                   (i_ope[6:4] == 3'b111));
  // Abort and halt both suppress the commit, so neither writes nor counts.
  assign w_exec      = (r_state == ST_RUN) & w_commit & ~i_abort & ~w_halt_op;
  assign w_load_acc  = (r_state == ST_LOAD) & i_load_valid;
  assign w_load_done = i_load_last | (r_ptr == PTR_MAX);
  assign w_ret_max   = &r_retired;

  // Memory write port: loader in LOAD, CPU push writes on executed commits.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_load_acc) begin
      o_mem_we    = 1'b1;
      o_mem_addr  = r_ptr;
      o_mem_wdata = i_load_data;
    end else if (w_exec) begin
      o_mem_we    = i_write_flag;
      o_mem_addr  = i_write_addr[AW-1:0];
      o_mem_wdata = i_write_value;
    end
  end

  // Sequencer FSM together with the architectural registers it commits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_sp      <= SP_INIT;
      r_ip      <= '0;
      r_zf      <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (i_load_start) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
          end else if (i_start) begin
            r_state   <= ST_RUN;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_sp      <= SP_INIT;
            r_ip      <= '0;
            r_zf      <= 1'b0;
            r_retired <= '0;
          end
        end
        ST_LOAD: begin
          if (w_load_acc) begin
            r_ptr <= r_ptr + 1'b1;
            if (w_load_done) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            r_state <= ST_HALT;
          end else if (w_commit) begin
            if (w_halt_op) begin
              r_state <= ST_HALT;
            end else begin
              r_a  <= i_next_a;
              r_b  <= i_next_b;
              r_c  <= i_next_c;
              r_d  <= i_next_d;
              r_sp <= i_next_sp;
              r_ip <= i_next_ip;
              r_zf <= i_next_zf;
              if (!w_ret_max) begin
                r_retired <= r_retired + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_c          = r_c;
  assign o_d          = r_d;
  assign o_sp         = r_sp;
  assign o_ip         = r_ip;
  assign o_zf         = r_zf;
  assign o_state      = r_state;
  assign o_halted     = (r_state == ST_HALT);
  assign o_load_ready = (r_state == ST_LOAD);
  assign o_retired    = r_retired;

endmodule
